// File: rtl/smpl_queue.sv
// Stereo sample queue feeding the FIR stage.
//
// Holds up to DEPTH-1 left/right 16-bit sample pairs in a circular buffer. Whenever at
// least READ_LEN samples are held, it streams the oldest READ_LEN of them, oldest first,
// one pair per clk, with `sequencing` high for the whole burst. The window then slides
// forward by one sample.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   wrt_smpl    one-cycle strobe, lft_smpl/rght_smpl valid
//   lft_smpl    left sample to store
//   rght_smpl   right sample to store
//   sequencing  high while lft_out/rght_out carry a burst sample
//   lft_out     registered left sample streamed to the FIR
//   rght_out    registered right sample streamed to the FIR
//   ovr         sticky overflow flag, cleared only by reset
module smpl_queue #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter int unsigned READ_LEN = 1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic        sequencing,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        ovr
);

  localparam logic [AW-1:0] ReadLen = AW'(READ_LEN);
  localparam logic [AW-1:0] LastCnt = AW'(READ_LEN - 1);
  localparam logic [AW-1:0] FullCnt = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StPrime, StSeq} state_e;

  logic [15:0] mem_l [DEPTH];
  logic [15:0] mem_r [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] new_ptr_q, old_ptr_q;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] held;
  logic [AW-1:0] rd_addr;
  logic          full;
  logic          wr_en;
  logic          rd_en;
  logic          slide;

  // One slot is kept free so new_ptr never lands on old_ptr: a burst only ever reads
  // old_ptr..old_ptr+READ_LEN-1, which a write can therefore never touch.
  assign held  = new_ptr_q - old_ptr_q;
  assign full  = (held == FullCnt);
  assign wr_en = wrt_smpl && !full;

  assign sequencing = (state_q == StSeq);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_l[new_ptr_q] <= lft_smpl;
      mem_r[new_ptr_q] <= rght_smpl;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rd_addr  = rd_ptr_q;
    rd_en    = 1'b0;
    slide    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (held >= ReadLen) state_d = StPrime;
      end
      StPrime: begin
        // Issue the first read so its data is on the outputs in the first SEQ cycle.
        rd_addr  = old_ptr_q;
        rd_en    = 1'b1;
        rd_ptr_d = old_ptr_q + 1'b1;
        cnt_d    = '0;
        state_d  = StSeq;
      end
      StSeq: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // Last sample is on the outputs; skip the read so they hold their value.
          state_d = StIdle;
          slide   = 1'b1;
        end else begin
          rd_en = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovr       <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (wr_en) new_ptr_q <= new_ptr_q + 1'b1;
      if (slide) old_ptr_q <= old_ptr_q + 1'b1;
      if (wrt_smpl && full) ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_out  <= '0;
      rght_out <= '0;
    end else if (rd_en) begin
      lft_out  <= mem_l[rd_addr];
      rght_out <= mem_r[rd_addr];
    end
  end

endmodule

// File: tb/tb_smpl_queue.sv
module tb_smpl_queue;

  localparam int DEPTH = 1024;
  localparam int RL    = 1021;

  logic        clk;
  logic        rst_n;
  logic        wrt_smpl;
  logic [15:0] lft_smpl;
  logic [15:0] rght_smpl;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  logic        ovr;

  smpl_queue #(
    .DEPTH   (DEPTH),
    .AW      (10),
    .READ_LEN(RL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt_smpl  (wrt_smpl),
    .lft_smpl  (lft_smpl),
    .rght_smpl (rght_smpl),
    .sequencing(sequencing),
    .lft_out   (lft_out),
    .rght_out  (rght_out),
    .ovr       (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } smp_t;

  typedef struct {
    string name;
    int    n_wr;
    int    gap;
    int    settle;
    int    exp_bursts;
    bit    exp_ovr;
  } row_t;

  row_t rows[8];

  // Scoreboard: accepted samples queued in arrival order; the front is the oldest
  // windowed sample, and each burst is compared against its first RL entries.
  smp_t win[$];
  int   ms;        // expected phase: 0 idle, 1 prime, 2 streaming
  int   mcnt;      // index within the current burst
  bit   ovr_exp;
  int   n;         // sample counter, lft=n, rght=~n
  bit   prev_seq;
  int   burst_cnt;
  int   errors;
  int   checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit wr);
    int  sz;
    bit  do_pop;
    @(negedge clk);
    chk("sequencing", {31'd0, sequencing}, {31'd0, ms == 2});
    if (ms == 2) begin
      if (mcnt < win.size()) begin
        chk("lft_out", {16'd0, lft_out}, {16'd0, win[mcnt].l});
        chk("rght_out", {16'd0, rght_out}, {16'd0, win[mcnt].r});
      end else begin
        chk("window underflow", mcnt, win.size());
      end
    end
    chk("ovr", {31'd0, ovr}, {31'd0, ovr_exp});
    if (prev_seq && !sequencing) burst_cnt++;
    prev_seq = sequencing;

    wrt_smpl  = wr;
    lft_smpl  = n[15:0];
    rght_smpl = ~n[15:0];

    // Predict the effect of the coming posedge from the values held this cycle.
    sz     = win.size();
    do_pop = 1'b0;
    case (ms)
      0: if (sz >= RL) ms = 1;
      1: begin
        ms   = 2;
        mcnt = 0;
      end
      default: begin
        if (mcnt == RL - 1) begin
          ms     = 0;
          do_pop = 1'b1;
        end else begin
          mcnt++;
        end
      end
    endcase
    if (wr) begin
      if (sz < DEPTH - 1) win.push_back({n[15:0], ~n[15:0]});
      else ovr_exp = 1'b1;
      n++;
    end
    if (do_pop) void'(win.pop_front());
  endtask

  task automatic apply_row(input int i);
    int b0;
    b0 = burst_cnt;
    for (int w = 0; w < rows[i].n_wr; w++) begin
      step(1'b1);
      for (int g = 0; g < rows[i].gap; g++) step(1'b0);
    end
    for (int s = 0; s < rows[i].settle; s++) step(1'b0);
    chk({rows[i].name, " bursts"}, burst_cnt - b0, rows[i].exp_bursts);
    chk({rows[i].name, " ovr"}, {31'd0, ovr}, {31'd0, rows[i].exp_ovr});
  endtask

  initial begin
    rows[0] = '{"fill",   1020, 0,    10,   0,  1'b0};
    rows[1] = '{"first",  1,    0,    1100, 1,  1'b0};
    rows[2] = '{"slide",  1,    0,    1100, 1,  1'b0};
    rows[3] = '{"mid2",   3,    500,  2200, 3,  1'b0};
    rows[4] = '{"mid3",   4,    300,  2600, 3,  1'b1};
    rows[5] = '{"wrap",   30,   1024, 10,   30, 1'b1};
    rows[6] = '{"refill", 1020, 0,    10,   0,  1'b0};
    rows[7] = '{"refire", 1,    0,    1100, 1,  1'b0};

    errors = 0; checks = 0; n = 0; ms = 0; mcnt = 0;
    ovr_exp = 1'b0; prev_seq = 1'b0; burst_cnt = 0;
    rst_n = 1'b0; wrt_smpl = 1'b0; lft_smpl = '0; rght_smpl = '0;

    repeat (3) @(negedge clk);
    chk("reset sequencing", {31'd0, sequencing}, 32'd0);
    chk("reset lft_out", {16'd0, lft_out}, 32'd0);
    chk("reset rght_out", {16'd0, rght_out}, 32'd0);
    chk("reset ovr", {31'd0, ovr}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) apply_row(i);

    // Reset in the middle of a burst: outputs must clear without waiting for a clock.
    step(1'b1);
    for (int c = 0; c < 502; c++) step(1'b0);
    chk("burst live before reset", {31'd0, sequencing}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset sequencing", {31'd0, sequencing}, 32'd0);
    chk("async reset lft_out", {16'd0, lft_out}, 32'd0);
    chk("async reset rght_out", {16'd0, rght_out}, 32'd0);
    chk("async reset ovr", {31'd0, ovr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    win.delete();
    ms = 0; mcnt = 0; ovr_exp = 1'b0; prev_seq = 1'b0;

    for (int i = 6; i < 8; i++) apply_row(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
